// File: rtl/jt12_eg_mux_pkg.sv
// Shared types and constants for the time-multiplexed envelope generator.
// The state encoding matters because per-slot state is stored as a raw 2-bit field.
package jt12_eg_mux_pkg;

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } eg_state_t;

    function automatic int slots_of(input int num_ch, input int num_op);
        return num_ch * num_op;
    endfunction

    // All-ones attenuation means silence.
    function automatic int eg_max_of(input int eg_w);
        return (1 << eg_w) - 1;
    endfunction

endpackage

// File: rtl/jt12_eg_mux_step.sv
// Combinational envelope step for one slot visit: it picks the rate, decides whether
// the level steps, applies key edges and phase transitions, and flags a release reaching silence.
module jt12_eg_mux_step
    import jt12_eg_mux_pkg::*;
#(
    parameter int EG_W  = 10,
    parameter int CNT_W = 15
) (
    input  eg_state_t        st,
    input  logic [EG_W-1:0]  lvl,
    input  logic             keyon,
    input  logic             kon_last,
    input  logic             eg_stop,
    input  logic [CNT_W-1:0] eg_cnt,
    input  logic [4:0]       arate,
    input  logic [4:0]       rate1,
    input  logic [4:0]       rate2,
    input  logic [3:0]       rrate,
    input  logic [3:0]       sl,
    output eg_state_t        st_next,
    output logic [EG_W-1:0]  lvl_next,
    output logic             free
);

    localparam logic [EG_W-1:0] LVL_MAX = EG_W'(eg_max_of(EG_W));

    logic [4:0]       rate;
    logic [4:0]       p_full;
    logic [3:0]       p;
    logic [CNT_W-1:0] cnt_mask;
    logic             do_step;
    logic [EG_W-1:0]  dec;
    logic [EG_W-1:0]  lvl_step;
    logic [EG_W-1:0]  lvl_upd;
    logic [EG_W-1:0]  thr;

    always_comb begin
        rate     = 5'd0;
        p_full   = 5'd0;
        p        = 4'd0;
        cnt_mask = '0;
        do_step  = 1'b0;
        dec      = '0;
        lvl_step = lvl;
        lvl_upd  = lvl;
        thr      = LVL_MAX;
        st_next  = st;
        lvl_next = lvl;
        free     = 1'b0;

        case (st)
            ST_ATTACK:  rate = arate;
            ST_DECAY:   rate = rate1;
            ST_SUSTAIN: rate = rate2;
            default:    rate = {rrate, 1'b1};
        endcase

        // A step happens every 2^p counter ticks, p = (31-rate)/2.
        p_full   = 5'd31 - rate;
        p        = p_full[4:1];
        cnt_mask = ~({CNT_W{1'b1}} << p);
        do_step  = (rate != 5'd0) && !eg_stop && ((eg_cnt & cnt_mask) == '0);

        dec = (lvl >> 4) + EG_W'(1);
        if (st == ST_ATTACK)
            lvl_step = (lvl > dec) ? (lvl - dec) : '0;
        else
            lvl_step = (lvl == LVL_MAX) ? LVL_MAX : (lvl + EG_W'(1));
        lvl_upd  = do_step ? lvl_step : lvl;
        lvl_next = lvl_upd;

        thr = (sl == 4'hF) ? LVL_MAX : {sl, {(EG_W-4){1'b0}}};

        if (keyon && !kon_last) begin
            lvl_next = lvl;
            if (arate == 5'd31) begin
                st_next  = ST_DECAY;
                lvl_next = '0;
            end else begin
                st_next  = ST_ATTACK;
            end
        end else if (!keyon && kon_last) begin
            st_next = ST_RELEASE;
        end else if (st == ST_ATTACK && lvl_upd == '0) begin
            st_next = ST_DECAY;
        end else if (st == ST_DECAY && lvl_upd >= thr) begin
            st_next = ST_SUSTAIN;
        end

        free = (st_next == ST_RELEASE) && (lvl_next == LVL_MAX) && (lvl != LVL_MAX);
    end

endmodule

// File: rtl/jt12_eg_mux.sv
// Time-multiplexed ADSR engine: the slot sequencer, the global envelope counter, per-slot
// state registers and the registered output stage around a shared step block.
module jt12_eg_mux
    import jt12_eg_mux_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int NUM_OP = 4,
    parameter int EG_W   = 10,
    parameter int CNT_W  = 15,
    localparam int SLOTS  = slots_of(NUM_CH, NUM_OP),
    localparam int SLOT_W = $clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              eg_stop,
    output logic [SLOT_W-1:0] slot,
    input  logic              keyon,
    input  logic [4:0]        arate,
    input  logic [4:0]        rate1,
    input  logic [4:0]        rate2,
    input  logic [3:0]        rrate,
    input  logic [3:0]        sl,
    output logic [EG_W-1:0]   eg_out,
    output logic [SLOT_W-1:0] eg_slot,
    output logic              eg_valid,
    output logic              free
);

    localparam logic [EG_W-1:0] LVL_MAX = EG_W'(eg_max_of(EG_W));

    logic [SLOT_W-1:0] slot_reg;
    logic [CNT_W-1:0]  eg_cnt_reg;
    logic              last_slot;

    logic [EG_W-1:0]   lvl_all [SLOTS];
    eg_state_t         st_all  [SLOTS];
    logic              kon_all [SLOTS];

    eg_state_t         st_next;
    logic [EG_W-1:0]   lvl_next;
    logic              free_next;

    assign last_slot = (slot_reg == SLOT_W'(SLOTS - 1));
    assign slot      = slot_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg   <= '0;
            eg_cnt_reg <= '0;
        end else if (clk_en) begin
            slot_reg <= last_slot ? '0 : slot_reg + SLOT_W'(1);
            if (last_slot && !eg_stop)
                eg_cnt_reg <= eg_cnt_reg + CNT_W'(1);
        end
    end

    // Each slot owns its registers; only the slot being visited loads the step result.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [EG_W-1:0] lvl_reg;
            eg_state_t       st_reg;
            logic            kon_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    lvl_reg <= LVL_MAX;
                    st_reg  <= ST_RELEASE;
                    kon_reg <= 1'b0;
                end else if (clk_en && slot_reg == SLOT_W'(gi)) begin
                    lvl_reg <= lvl_next;
                    st_reg  <= st_next;
                    kon_reg <= keyon;
                end
            end

            assign lvl_all[gi] = lvl_reg;
            assign st_all[gi]  = st_reg;
            assign kon_all[gi] = kon_reg;
        end
    endgenerate

    jt12_eg_mux_step #(
        .EG_W  (EG_W),
        .CNT_W (CNT_W)
    ) u_step (
        .st       (st_all[slot_reg]),
        .lvl      (lvl_all[slot_reg]),
        .keyon    (keyon),
        .kon_last (kon_all[slot_reg]),
        .eg_stop  (eg_stop),
        .eg_cnt   (eg_cnt_reg),
        .arate    (arate),
        .rate1    (rate1),
        .rate2    (rate2),
        .rrate    (rrate),
        .sl       (sl),
        .st_next  (st_next),
        .lvl_next (lvl_next),
        .free     (free_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            eg_out   <= LVL_MAX;
            eg_slot  <= '0;
            eg_valid <= 1'b0;
            free     <= 1'b0;
        end else begin
            eg_valid <= clk_en;
            if (clk_en) begin
                eg_out  <= lvl_next;
                eg_slot <= slot_reg;
                free    <= free_next;
            end
        end
    end

endmodule

// File: tb/tb_jt12_eg_mux.sv
// Scoreboard bench for jt12_eg_mux: the driver queues hand-derived expectations per visit,
// the monitor pops and compares whenever eg_valid is high.
module tb_jt12_eg_mux;

    localparam int SLOTS = 24;

    logic       clk = 1'b0;
    logic       rst, clk_en, eg_stop, keyon;
    logic [4:0] arate, rate1, rate2;
    logic [3:0] rrate, sl;
    logic [4:0] slot, eg_slot;
    logic [9:0] eg_out;
    logic       eg_valid, free;

    always #5 clk = ~clk;

    jt12_eg_mux dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .eg_stop  (eg_stop),
        .slot     (slot),
        .keyon    (keyon),
        .arate    (arate),
        .rate1    (rate1),
        .rate2    (rate2),
        .rrate    (rrate),
        .sl       (sl),
        .eg_out   (eg_out),
        .eg_slot  (eg_slot),
        .eg_valid (eg_valid),
        .free     (free)
    );

    typedef struct packed {
        logic [4:0] s;
        logic [9:0] l;
        logic       f;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cur_slot = 0;
    logic [14:0] cnt_m = '0;
    logic        k0 = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one clk_en cycle for the bench's own slot counter and queue the expected output.
    task automatic step_cycle(input logic en, input logic [9:0] e0, input logic f0);
        exp_t e;
        clk_en = en;
        keyon  = (cur_slot == 0) ? k0 : 1'b0;
        chk("slot", int'(slot), cur_slot);
        if (en) begin
            e.s = 5'(cur_slot);
            e.l = (cur_slot == 0) ? e0 : 10'h3FF;
            e.f = (cur_slot == 0) ? f0 : 1'b0;
            sb.push_back(e);
            if (cur_slot == SLOTS - 1 && !eg_stop)
                cnt_m++;
            cur_slot = (cur_slot + 1) % SLOTS;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input int n, input logic [9:0] e0);
        clk_en = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
            chk("hold_eg_out", int'(eg_out), int'(e0));
            chk("hold_slot", int'(slot), cur_slot);
            chk("hold_eg_slot", int'(eg_slot), 0);
            chk("hold_eg_valid", int'(eg_valid), 0);
        end
    endtask

    // One full rotation; slot 0 gets keyon=kon and is expected to show e0/f0.
    task automatic round(input logic kon, input logic [9:0] e0, input logic f0, input int hold_n);
        k0 = kon;
        $display("round kon=%0d cnt=%0h slot0 expect eg_out=%03h free=%0d", kon, cnt_m, e0, f0);
        for (int i = 0; i < SLOTS; i++) begin
            step_cycle(1'b1, e0, f0);
            if (i == 0 && hold_n > 0)
                hold(hold_n, e0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && eg_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: output slot %0d with nothing expected", eg_slot);
            end else begin
                mon_e = sb.pop_front();
                chk("eg_slot", int'(eg_slot), int'(mon_e.s));
                chk("eg_out", int'(eg_out), int'(mon_e.l));
                chk("free", int'(free), int'(mon_e.f));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] e;
        int         n;
        rst = 1'b1; clk_en = 1'b0; eg_stop = 1'b0; keyon = 1'b0;
        arate = 5'd0; rate1 = 5'd0; rate2 = 5'd0; rrate = 4'd0; sl = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_eg_out", int'(eg_out), 10'h3FF);
        chk("rst_eg_slot", int'(eg_slot), 0);
        chk("rst_eg_valid", int'(eg_valid), 0);
        chk("rst_free", int'(free), 0);
        chk("rst_slot", int'(slot), 0);
        rst = 1'b0;

        // Idle: every slot stays silent, free never fires.
        repeat (2) round(1'b0, 10'h3FF, 1'b0, 0);

        // Instant attack lands at 0 in DECAY; rate1=0 keeps it there.
        arate = 5'd31; rate1 = 5'd0; sl = 4'd2;
        repeat (2) round(1'b1, 10'h000, 1'b0, 0);

        // Decay by 1 per visit up to the 0x080 threshold, then SUSTAIN with rate2=0 holds.
        rate1 = 5'd31; rate2 = 5'd0;
        for (int i = 1; i <= 128; i++) round(1'b1, 10'(i), 1'b0, 0);
        repeat (3) round(1'b1, 10'h080, 1'b0, 0);

        // Sustain climb to 0x3F0, then release to silence with one free pulse.
        rate2 = 5'd31;
        for (int v = 16'h081; v <= 16'h3F0; v++) round(1'b1, 10'(v), 1'b0, 0);
        rrate = 4'd15;
        for (int v = 16'h3F1; v <= 16'h3FF; v++)
            round(1'b0, 10'(v), v == 16'h3FF, (v == 16'h3F4) ? 7 : 0);
        repeat (2) round(1'b0, 10'h3FF, 1'b0, 0);

        // eg_stop: key-on edge still enters ATTACK but the level is frozen.
        eg_stop = 1'b1; arate = 5'd30;
        repeat (4) round(1'b1, 10'h3FF, 1'b0, 0);
        eg_stop = 1'b0;
        round(1'b1, 10'h3BF, 1'b0, 0);

        // Key off from ATTACK: the last attack step applies, then release climbs to silence.
        round(1'b0, 10'h383, 1'b0, 0);
        for (int v = 16'h384; v <= 16'h3FF; v++) round(1'b0, 10'(v), v == 16'h3FF, 0);
        round(1'b0, 10'h3FF, 1'b0, 0);

        // Slow attack (p=5): only visits with eg_cnt[4:0]==0 step the level.
        arate = 5'd20;
        round(1'b1, 10'h3FF, 1'b0, 0);
        e = 10'h3FF;
        n = 0;
        for (int r = 0; r < 80 && n < 2; r++) begin
            if (cnt_m[4:0] == 5'd0) begin
                n++;
                e = (n == 1) ? 10'h3BF : 10'h383;
            end
            round(1'b1, e, 1'b0, 0);
        end

        // Reset with clk_en high returns everything to idle.
        rst = 1'b1; clk_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst2_eg_out", int'(eg_out), 10'h3FF);
        chk("rst2_eg_valid", int'(eg_valid), 0);
        chk("rst2_slot", int'(slot), 0);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
